// File: rtl/mul_issue_ctrl_if.sv
// Bundle between the EX-stage multiply issue controller, its op source / result sink and the shared multiplier.
// The slave view belongs to the controller; the master view is the surrounding pipeline and multiplier.
interface mul_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_src1;
    logic [31:0]      in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             mul_sign;
    logic [31:0]      mul_x;
    logic [31:0]      mul_y;
    logic             mul_start;
    logic [63:0]      mul_result;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output flush, in_valid, in_op, in_src1, in_src2, in_tag, mul_result, out_ready,
        input  in_ready, mul_sign, mul_x, mul_y, mul_start, out_valid, out_data, out_tag, busy
    );

    modport slave (
        input  flush, in_valid, in_op, in_src1, in_src2, in_tag, mul_result, out_ready,
        output in_ready, mul_sign, mul_x, mul_y, mul_start, out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue controller for the shared 2-stage multiplier: issues MUL.W / MULH.W / MULH.WU, selects the
// product half one cycle later and queues tagged results in an in-order FIFO with flush.
module mul_issue_ctrl_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             mul_clk,
    input logic             reset,
    input logic             push_s,
    input logic [CNT_W-1:0] count_r
);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    a_no_push_when_full: assert property (@(posedge mul_clk) disable iff (reset)
        !(push_s && (count_r == FULL_C)));

    a_count_in_range: assert property (@(posedge mul_clk) disable iff (reset)
        count_r <= FULL_C);
endmodule

module mul_issue_ctrl #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 4
) (
    input logic             mul_clk,
    input logic             reset,
    mul_issue_ctrl_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 32 + TAG_W;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic             s1_valid_r;
    logic             s1_hi_r;
    logic [TAG_W-1:0] s1_tag_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [ENT_W-1:0] fifo_mem_r [DEPTH];
    logic [CNT_W:0]   occupancy_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             out_valid_s;
    logic             push_s;
    logic             pop_s;
    logic             op_hi_s;
    logic [31:0]      push_data_s;

    // Handshake gating: a slot is reserved for the op sitting in stage 1, so pop never feeds in_ready
    always_comb begin
        occupancy_s = {1'b0, count_r} + {{CNT_W{1'b0}}, s1_valid_r};
        if (!reset && !bus.flush && (occupancy_s < DEPTH_C)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s    = bus.in_valid && in_ready_s;
        out_valid_s = !reset && !bus.flush && (count_r != {CNT_W{1'b0}});
        pop_s       = out_valid_s && bus.out_ready;
        push_s      = s1_valid_r && !bus.flush;
        op_hi_s     = (bus.in_op == 2'b01) || (bus.in_op == 2'b10);
        if (s1_hi_r) begin
            push_data_s = bus.mul_result[63:32];
        end else begin
            push_data_s = bus.mul_result[31:0];
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.mul_start = accept_s;
    assign bus.mul_sign  = (bus.in_op == 2'b01);
    assign bus.mul_x     = bus.in_src1;
    assign bus.mul_y     = bus.in_src2;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = fifo_mem_r[rd_ptr_r][ENT_W-1:TAG_W];
    assign bus.out_tag   = fifo_mem_r[rd_ptr_r][TAG_W-1:0];
    assign bus.busy      = s1_valid_r || (count_r != {CNT_W{1'b0}});

    // FIFO occupancy and pointer next-state; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        count_nxt_s  = count_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
            2'b11:   count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1'b1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Stage-1 tracker: remembers which half and tag belong to the product arriving next cycle
    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_hi_r    <= 1'b0;
            s1_tag_r   <= {TAG_W{1'b0}};
        end else if (bus.flush) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_hi_r  <= op_hi_s;
                s1_tag_r <= bus.in_tag;
            end
        end
    end

    // FIFO control state; flush wins over any push or pop in the same cycle
    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (bus.flush) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            count_r  <= count_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
        end
    end

    // Result storage, deliberately left unreset
    always_ff @(posedge mul_clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {push_data_s, s1_tag_r};
        end
    end

    mul_issue_ctrl_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .mul_clk (mul_clk),
        .reset   (reset),
        .push_s  (push_s),
        .count_r (count_r)
    );
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural 1-cycle multiplier model.
module tb_mul_issue_ctrl;
    localparam int TAG_W = 5;
    localparam int DEPTH = 4;

    logic        mul_clk = 1'b0;
    logic        reset   = 1'b0;
    logic [63:0] prod_r  = 64'h0;
    int          checks  = 0;
    int          errors  = 0;

    mul_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    mul_issue_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .mul_clk (mul_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 mul_clk = ~mul_clk;

    // Multiplier model: operands captured at the issue edge, product valid the following cycle
    always_ff @(posedge mul_clk) begin
        if (bus.mul_start) begin
            if (bus.mul_sign)
                prod_r <= 64'($signed({{32{bus.mul_x[31]}}, bus.mul_x}) * $signed({{32{bus.mul_y[31]}}, bus.mul_y}));
            else
                prod_r <= {32'h0, bus.mul_x} * {32'h0, bus.mul_y};
        end
    end
    assign bus.mul_result = prod_r;

    task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = a;
        bus.in_src2  = b;
        bus.in_tag   = t;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_op    = 2'b00;
        bus.in_src1  = 32'h0;
        bus.in_src2  = 32'h0;
        bus.in_tag   = '0;
    endtask

    task automatic test_reset();
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive_op(2'b00, 32'd1, 32'd1, 5'd1);
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start got %b exp 0", bus.mul_start); end
        drive_idle();
        repeat (2) @(negedge mul_clk);
        reset = 1'b0;
        @(negedge mul_clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        @(negedge mul_clk);
        drive_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3);
        #1;
        checks++; if (bus.mul_start !== 1'b1 || bus.mul_sign !== 1'b0) begin errors++; $display("FAIL single_issue got start %b sign %b exp 1 0", bus.mul_start, bus.mul_sign); end
        @(negedge mul_clk);
        drive_idle();
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_stage1 got valid %b busy %b exp 0 1", bus.out_valid, bus.busy); end
        @(negedge mul_clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_FFEB || bus.out_tag !== 5'd3) begin
            errors++; $display("FAIL single_result got v %b data %h tag %0d exp 1 ffffffeb 3", bus.out_valid, bus.out_data, bus.out_tag); end
        @(negedge mul_clk);
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got busy %b valid %b exp 0 0", bus.busy, bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [4];
        logic [31:0] a [4];
        logic [31:0] exp_d [4];
        logic        exp_s [4];
        ops = '{2'b01, 2'b10, 2'b01, 2'b11};
        a   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005};
        exp_d = '{32'h4000_0000, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_001E};
        exp_s = '{1'b1, 1'b0, 1'b1, 1'b0};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge mul_clk);
            if (c >= 2) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[c-2] || bus.out_tag !== TAG_W'(10 + c - 2)) begin
                    errors++; $display("FAIL b2b_result%0d got v %b data %h tag %0d exp 1 %h %0d", c-2, bus.out_valid, bus.out_data, bus.out_tag, exp_d[c-2], 10 + c - 2); end
            end
            if (c < 4) begin
                drive_op(ops[c], a[c], (c == 3) ? 32'd6 : a[c], TAG_W'(10 + c));
                #1;
                checks++;
                if (bus.mul_sign !== exp_s[c] || bus.in_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_issue%0d got sign %b ready %b exp %b 1", c, bus.mul_sign, bus.in_ready, exp_s[c]); end
            end else begin
                drive_idle();
            end
        end
    endtask

    task automatic test_backpressure();
        int   sent = 0;
        int   rcv  = 0;
        logic pend = 1'b0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 60 && rcv < 6; c++) begin
            @(negedge mul_clk);
            if (c == 10) bus.out_ready = 1'b1;
            if (pend) sent++;
            if (c == 9) begin
                checks++;
                if (sent !== 4 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_full got sent %0d ready %b valid %b exp 4 0 1", sent, bus.in_ready, bus.out_valid); end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_tag !== TAG_W'(rcv) || bus.out_data !== 32'((rcv + 1) * 10)) begin
                    errors++; $display("FAIL bp_result%0d got data %h tag %0d exp %h %0d", rcv, bus.out_data, bus.out_tag, (rcv + 1) * 10, rcv); end
                rcv++;
            end
            if (sent < 6) drive_op(2'b00, 32'(sent + 1), 32'd10, TAG_W'(sent));
            else drive_idle();
            #1 pend = bus.in_valid && bus.in_ready;
        end
        drive_idle();
        checks++; if (rcv !== 6 || sent !== 6) begin errors++; $display("FAIL bp_drain got rcv %0d sent %0d exp 6 6", rcv, sent); end
    endtask

    task automatic test_wrap();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge mul_clk);
            if (c >= 2) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_tag !== TAG_W'(c - 2) || bus.out_data !== 32'((c + 1) * (c + 3))) begin
                    errors++; $display("FAIL wrap_result%0d got v %b data %h tag %0d exp 1 %h %0d", c-2, bus.out_valid, bus.out_data, bus.out_tag, (c + 1) * (c + 3), c - 2); end
            end
            if (c < 12) begin
                drive_op(2'b00, 32'(c + 3), 32'(c + 5), TAG_W'(c));
                #1;
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready%0d got %b exp 1", c, bus.in_ready); end
            end else begin
                drive_idle();
            end
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge mul_clk);
            drive_op(2'b00, 32'd9, 32'd9, TAG_W'(20 + c));
        end
        @(negedge mul_clk);
        drive_op(2'b00, 32'd1, 32'd1, 5'd30);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.mul_start !== 1'b0) begin
            errors++; $display("FAIL flush_cycle got valid %b ready %b start %b exp 0 0 0", bus.out_valid, bus.in_ready, bus.mul_start); end
        @(negedge mul_clk);
        bus.flush = 1'b0;
        drive_idle();
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got busy %b valid %b exp 0 0", bus.busy, bus.out_valid); end
        bus.out_ready = 1'b1;
        drive_op(2'b01, 32'hFFFF_FFFE, 32'd3, 5'd23);
        @(negedge mul_clk);
        drive_idle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_early got valid %b exp 0", bus.out_valid); end
        @(negedge mul_clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_FFFF || bus.out_tag !== 5'd23) begin
            errors++; $display("FAIL flush_new_op got v %b data %h tag %0d exp 1 ffffffff 23", bus.out_valid, bus.out_data, bus.out_tag); end
        for (int c = 0; c < 3; c++) begin
            @(negedge mul_clk);
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_killed got valid %b tag %0d exp 0", bus.out_valid, bus.out_tag); end
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge mul_clk);
            drive_op(2'b00, 32'd4, 32'd4, TAG_W'(1 + c));
        end
        @(negedge mul_clk);
        drive_idle();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL areset_pre got busy %b exp 1", bus.busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL areset_drop got ready %b valid %b busy %b exp 0 0 0", bus.in_ready, bus.out_valid, bus.busy); end
        repeat (2) @(negedge mul_clk);
        reset = 1'b0;
        @(negedge mul_clk);
        bus.out_ready = 1'b1;
        drive_op(2'b00, 32'd2, 32'd3, 5'd7);
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.mul_start !== 1'b1) begin errors++; $display("FAIL areset_issue got ready %b start %b exp 1 1", bus.in_ready, bus.mul_start); end
        @(negedge mul_clk);
        drive_idle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_early got valid %b exp 0", bus.out_valid); end
        @(negedge mul_clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_0006 || bus.out_tag !== 5'd7) begin
            errors++; $display("FAIL areset_result got v %b data %h tag %0d exp 1 00000006 7", bus.out_valid, bus.out_data, bus.out_tag); end
        @(negedge mul_clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL areset_idle got busy %b exp 0", bus.busy); end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_single();
        test_back_to_back();
        repeat (2) @(negedge mul_clk);
        test_backpressure();
        repeat (3) @(negedge mul_clk);
        test_wrap();
        repeat (2) @(negedge mul_clk);
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
